// File: rtl/fpu_tb_pkg.sv
// rtl/fpu_tb_pkg.sv - shared state encoding, flag positions and defaults for the FPU batch driver
package fpu_tb_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_BEGIN   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_CLEAR   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    // Bit positions inside res_flags
    localparam int OVF = 1;
    localparam int UNF = 0;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/fpu_wait_timer.sv
// rtl/fpu_wait_timer.sv - loadable wait counter with terminal-count flag
module fpu_wait_timer #(
    parameter int CW    = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [CW:0] LIM = LIMIT[CW:0];

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Load clears, enable counts up; count stops at the terminal cycle
    always_comb begin
        cnt_d = cnt_q;
        if (load)          cnt_d = '0;
        else if (en && !tc) cnt_d = cnt_q + 1'b1;
    end

    // The cycle count seen by the waiter is cnt_q+1: first waiting cycle counts as 1
    assign tc = ({1'b0, cnt_q} + 1'b1) == LIM;

endmodule

// File: rtl/fpu_batch_driver.sv
// rtl/fpu_batch_driver.sv - batch initiator for the FPU beg_FSM/ready/rst_FSM handshake
module fpu_batch_driver
    import fpu_tb_pkg::*;
#(
    parameter int W       = 64,
    parameter int AW      = 10,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   num_ops,
    input  logic          add_subt_cfg,
    input  logic [1:0]    r_mode_cfg,
    output logic          op_rd_en,
    output logic [AW-1:0] op_addr,
    input  logic [W-1:0]  op_x,
    input  logic [W-1:0]  op_y,
    output logic          beg_FSM,
    output logic          rst_FSM,
    output logic [W-1:0]  Data_X,
    output logic [W-1:0]  Data_Y,
    output logic          add_subt,
    output logic [1:0]    r_mode,
    input  logic          ready,
    input  logic [W-1:0]  final_result_ieee,
    input  logic          overflow_flag,
    input  logic          underflow_flag,
    output logic          res_wr_en,
    output logic [AW-1:0] res_addr,
    output logic [W-1:0]  res_data,
    output logic [1:0]    res_flags,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [AW-1:0] err_index
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   index_q, index_d;
    logic [AW:0]   num_q, num_d;
    logic          asub_q, asub_d;
    logic [1:0]    rmode_q, rmode_d;
    logic [W-1:0]  dx_q, dx_d;
    logic [W-1:0]  dy_q, dy_d;
    logic          terr_q, terr_d;
    logic [AW-1:0] eidx_q, eidx_d;
    logic [AW:0]   idx_inc;
    logic          tc;

    assign idx_inc = index_q + {{AW{1'b0}}, 1'b1};

    fpu_wait_timer #(
        .CW    (CW),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == S_BEGIN),
        .en   (state_q == S_WAIT),
        .tc   (tc)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            index_q <= '0;
            num_q   <= '0;
            asub_q  <= 1'b0;
            rmode_q <= 2'b00;
            dx_q    <= '0;
            dy_q    <= '0;
            terr_q  <= 1'b0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            num_q   <= num_d;
            asub_q  <= asub_d;
            rmode_q <= rmode_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            terr_q  <= terr_d;
            eidx_q  <= eidx_d;
        end
    end

    // Next-state: ready wins over the timeout on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (num_ops == '0) ? S_DONE : S_FETCH;
            S_FETCH:   state_d = S_LOAD;
            S_LOAD:    state_d = S_BEGIN;
            S_BEGIN:   state_d = S_WAIT;
            S_WAIT: begin
                if (ready)   state_d = S_CAPTURE;
                else if (tc) state_d = S_CLEAR;
            end
            S_CAPTURE: state_d = S_CLEAR;
            S_CLEAR:   state_d = (idx_inc == num_q || terr_q) ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath updates: batch config on start, operands on LOAD, error capture on abort
    always_comb begin
        index_d = index_q;
        num_d   = num_q;
        asub_d  = asub_q;
        rmode_d = rmode_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        terr_d  = terr_q;
        eidx_d  = eidx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_ops;
                    asub_d  = add_subt_cfg;
                    rmode_d = r_mode_cfg;
                    terr_d  = 1'b0;
                    index_d = '0;
                end
            end
            S_LOAD: begin
                dx_d = op_x;
                dy_d = op_y;
            end
            S_WAIT: begin
                if (!ready && tc) begin
                    terr_d = 1'b1;
                    eidx_d = index_q[AW-1:0];
                end
            end
            S_CLEAR:  index_d = idx_inc;
            default:  ;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        op_rd_en  = (state_q == S_FETCH);
        op_addr   = (state_q == S_FETCH) ? index_q[AW-1:0] : '0;
        beg_FSM   = (state_q == S_BEGIN);
        rst_FSM   = (state_q == S_CLEAR);
        res_wr_en = (state_q == S_CAPTURE);
        res_addr  = '0;
        res_data  = '0;
        res_flags = 2'b00;
        if (state_q == S_CAPTURE) begin
            res_addr       = index_q[AW-1:0];
            res_data       = final_result_ieee;
            res_flags[OVF] = overflow_flag;
            res_flags[UNF] = underflow_flag;
        end
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        done        = (state_q == S_DONE);
        Data_X      = dx_q;
        Data_Y      = dy_q;
        add_subt    = asub_q;
        r_mode      = rmode_q;
        timeout_err = terr_q;
        err_index   = eidx_q;
    end

endmodule
